// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory, its load controller and the fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

  // Geometry defaults shared by the memory, the fetch stage and the load controller.
  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 256;

  // Load controller state encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_LOAD = LOAD,
    S_DONE = DONE
  } imem_state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Arbitrates the single instruction-memory port between CPU fetch and a program loader.
// Latency: fetch is combinational pass-through; each loader beat is written on the edge that accepts it.
// Backpressure: ld_ready_o is high for the whole LOAD state; the loader may insert bubbles indefinitely.
//
// Ports: clk_i/rst_ni (async active-low); ld_start_i/ld_base_i/ld_len_i open a session;
// ld_valid_i/ld_data_i/ld_ready_o carry loader words; ld_busy_o/ld_done_o/ld_err_o report status;
// fetch_addr_i/fetch_data_o/fetch_valid_o/cpu_stall_o face the fetch stage;
// mem_write_o/mem_addr_o/mem_datain_o/mem_dataout_i drive the memory pins.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic [ADDR_W-1:0] ld_len_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              ld_err_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] fetch_data_o,
  output logic              fetch_valid_o,
  output logic              cpu_stall_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_datain_o,
  input  logic [DATA_W-1:0] mem_dataout_i
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  imem_state_t       state_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [ADDR_W-1:0] rem_cnt_q;
  logic              err_q;
  logic              range_err;

  // One extra bit so base + len cannot wrap and sneak past the bound.
  assign range_err = (({1'b0, ld_base_i} + {1'b0, ld_len_i}) > DEPTH_LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_cnt_q <= '0;
      rem_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ld_start_i) begin
            if (range_err) begin
              err_q <= 1'b1;
            end else if (ld_len_i == '0) begin
              state_q <= S_DONE;
            end else begin
              addr_cnt_q <= ld_base_i;
              rem_cnt_q  <= ld_len_i;
              state_q    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // ld_ready_o is constant-high here, so ld_valid_i alone marks an accepted beat.
          if (ld_valid_i) begin
            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
            rem_cnt_q  <= rem_cnt_q - ADDR_W'(1);
            if (rem_cnt_q == ADDR_W'(1)) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ld_ready_o    = 1'b0;
    ld_busy_o     = 1'b0;
    ld_done_o     = 1'b0;
    cpu_stall_o   = 1'b0;
    fetch_valid_o = 1'b1;
    mem_write_o   = 1'b0;
    mem_addr_o    = fetch_addr_i;
    case (state_q)
      S_LOAD: begin
        ld_ready_o    = 1'b1;
        ld_busy_o     = 1'b1;
        cpu_stall_o   = 1'b1;
        fetch_valid_o = 1'b0;
        mem_write_o   = ld_valid_i;
        mem_addr_o    = addr_cnt_q;
      end
      S_DONE: begin
        ld_done_o     = 1'b1;
        ld_busy_o     = 1'b1;
        cpu_stall_o   = 1'b1;
        fetch_valid_o = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign ld_err_o     = err_q;
  assign mem_datain_o = ld_data_i;
  // Raw read data; consumers qualify it with fetch_valid_o.
  assign fetch_data_o = mem_dataout_i;

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic [15:0] ld_base;
  logic [15:0] ld_len;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;
  logic [15:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        cpu_stall;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  int n_chk = 0;
  int n_err = 0;

  // Memory attached to the DUT pins, and the reference image predicted by the bench.
  logic [31:0] tb_mem  [256];
  logic [31:0] exp_mem [256];
  int          wr_count = 0;
  int          done_cnt = 0;
  logic [15:0] last_wr_addr = '0;

  imem_load_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ld_start_i   (ld_start),
    .ld_base_i    (ld_base),
    .ld_len_i     (ld_len),
    .ld_valid_i   (ld_valid),
    .ld_data_i    (ld_data),
    .ld_ready_o   (ld_ready),
    .ld_busy_o    (ld_busy),
    .ld_done_o    (ld_done),
    .ld_err_o     (ld_err),
    .fetch_addr_i (fetch_addr),
    .fetch_data_o (fetch_data),
    .fetch_valid_o(fetch_valid),
    .cpu_stall_o  (cpu_stall),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_datain_o (mem_datain),
    .mem_dataout_i(mem_dataout)
  );

  always #5 clk = ~clk;

  assign mem_dataout = (mem_addr < 16'd256) ? tb_mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_addr < 16'd256) tb_mem[mem_addr[7:0]] <= mem_datain;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_addr;
    end
    if (ld_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++) begin
      if (tb_mem[i] !== exp_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s mem_image: %0d words differ, first at %0d got %h want %h",
               name, bad, first, tb_mem[first], exp_mem[first]);
    end
  endtask

  // Drives one session and checks it cycle by cycle against the expected protocol.
  // vpat gives ld_valid per LOAD cycle (beyond 32 cycles valid is held high) unless rand_v.
  task automatic run_load(input logic [15:0] base, input logic [15:0] len,
                          input logic [31:0] vpat, input bit rand_v,
                          input bit fixed, input logic [31:0] first_word,
                          input int restart_at, input string name);
    logic [31:0] words[$];
    logic [15:0] ea;
    int beats, cyc, w0;
    bit v;
    w0 = wr_count;
    for (int i = 0; i < int'(len); i++)
      words.push_back(fixed ? first_word + 32'(i) : $urandom);
    @(negedge clk);
    ld_start = 1; ld_base = base; ld_len = len; ld_valid = 0;
    @(negedge clk);
    ld_start = 0;
    beats = 0; cyc = 0;
    while (beats < int'(len) && cyc < 2000) begin
      v = rand_v ? bit'($urandom_range(0, 1)) : (cyc < 32 ? vpat[cyc] : 1'b1);
      ld_valid = v;
      ld_data  = v ? words[beats] : $urandom;
      ld_start = (cyc == restart_at);
      if (cyc == restart_at) begin ld_base = 16'd0; ld_len = 16'd1; end
      ea = base + 16'(beats);
      #1;
      n_chk++;
      if (ld_ready !== 1'b1 || cpu_stall !== 1'b1 || ld_busy !== 1'b1 || fetch_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s load_status cyc%0d: rdy=%b stall=%b busy=%b fv=%b want 1 1 1 0",
                 name, cyc, ld_ready, cpu_stall, ld_busy, fetch_valid);
      end
      n_chk++;
      if (mem_write !== v || ld_err !== 1'b0 || ld_done !== 1'b0) begin
        n_err++;
        $display("FAIL %s load_ctl cyc%0d: we=%b err=%b done=%b want %b 0 0",
                 name, cyc, mem_write, ld_err, ld_done, v);
      end
      if (v) begin
        n_chk++;
        if (mem_addr !== ea) begin
          n_err++;
          $display("FAIL %s load_addr beat%0d: got %0d want %0d", name, beats, mem_addr, ea);
        end
      end
      @(negedge clk);
      if (v) beats++;
      cyc++;
    end
    ld_valid = 0; ld_start = 0;
    n_chk++;
    if (cyc >= 2000) begin
      n_err++;
      $display("FAIL %s timeout: beats %0d want %0d", name, beats, len);
    end
    #1;
    n_chk++;
    if (ld_done !== 1'b1 || ld_ready !== 1'b0 || mem_write !== 1'b0 || cpu_stall !== 1'b1 || fetch_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_cycle: done=%b rdy=%b we=%b stall=%b fv=%b want 1 0 0 1 0",
               name, ld_done, ld_ready, mem_write, cpu_stall, fetch_valid);
    end
    @(negedge clk); #1;
    n_chk++;
    if (ld_done !== 1'b0 || fetch_valid !== 1'b1 || cpu_stall !== 1'b0 || ld_busy !== 1'b0 || ld_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s back_idle: done=%b fv=%b stall=%b busy=%b err=%b want 0 1 0 0 0",
               name, ld_done, fetch_valid, cpu_stall, ld_busy, ld_err);
    end
    for (int i = 0; i < int'(len); i++) exp_mem[int'(base) + i] = words[i];
    n_chk++;
    if (wr_count - w0 != int'(len) || last_wr_addr !== base + len - 16'd1) begin
      n_err++;
      $display("FAIL %s write_count: got %0d last %0d want %0d last %0d",
               name, wr_count - w0, last_wr_addr, len, base + len - 16'd1);
    end
    check_mem(name);
  endtask

  task automatic test_reset;
    logic [15:0] base = 16'd20;
    int d0;
    #1;
    n_chk++;
    if (ld_ready !== 0 || ld_busy !== 0 || ld_done !== 0 || ld_err !== 0 ||
        cpu_stall !== 0 || mem_write !== 0 || fetch_valid !== 1) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b busy=%b done=%b err=%b stall=%b we=%b fv=%b want 0 0 0 0 0 0 1",
               ld_ready, ld_busy, ld_done, ld_err, cpu_stall, mem_write, fetch_valid);
    end
    @(negedge clk); rst_n = 1;
    d0 = done_cnt;
    // Start a 5-word session and pull reset after two beats.
    @(negedge clk);
    ld_start = 1; ld_base = base; ld_len = 16'd5;
    @(negedge clk);
    ld_start = 0;
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1; ld_data = 32'h1000 + 32'(k);
      @(negedge clk);
    end
    ld_valid = 1; ld_data = 32'h1002;
    rst_n = 0;
    #1;
    n_chk++;
    if (ld_ready !== 0 || ld_busy !== 0 || ld_done !== 0 || cpu_stall !== 0 ||
        mem_write !== 0 || fetch_valid !== 1) begin
      n_err++;
      $display("FAIL reset_midload: rdy=%b busy=%b done=%b stall=%b we=%b fv=%b want 0 0 0 0 0 1",
               ld_ready, ld_busy, ld_done, cpu_stall, mem_write, fetch_valid);
    end
    @(negedge clk);
    ld_valid = 0;
    rst_n = 1;
    @(negedge clk); #1;
    n_chk++;
    if (ld_busy !== 0 || cpu_stall !== 0 || done_cnt != d0) begin
      n_err++;
      $display("FAIL reset_after: busy=%b stall=%b done_pulses=%0d want 0 0 0",
               ld_busy, cpu_stall, done_cnt - d0);
    end
    exp_mem[20] = 32'h1000;
    exp_mem[21] = 32'h1001;
    check_mem("reset_partial");
  endtask

  task automatic test_basic;
    run_load(16'd4, 16'd3, 32'hFFFF_FFFF, 0, 1, 32'hA, -1, "basic");
  endtask

  task automatic test_fetch;
    @(negedge clk);
    fetch_addr = 16'd4;
    #1;
    n_chk++;
    if (fetch_data !== 32'hA || fetch_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_pass: data=%h fv=%b want 0000000a 1", fetch_data, fetch_valid);
    end
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 16'($urandom_range(0, 255));
      #1;
      n_chk++;
      if (fetch_data !== exp_mem[fetch_addr[7:0]] || mem_addr !== fetch_addr) begin
        n_err++;
        $display("FAIL fetch_rand addr %0d: data=%h maddr=%0d want %h %0d",
                 fetch_addr, fetch_data, mem_addr, exp_mem[fetch_addr[7:0]], fetch_addr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bubbles;
    // valid 1,0,0,1
    run_load(16'd40, 16'd2, 32'b1001, 0, 0, 32'h0, -1, "bubbles");
  endtask

  task automatic test_bounds;
    int w0 = wr_count;
    @(negedge clk);
    ld_start = 1; ld_base = 16'd250; ld_len = 16'd7;
    #1;
    n_chk++;
    if (ld_err !== 1'b0) begin
      n_err++;
      $display("FAIL bounds_err_early: err=%b want 0", ld_err);
    end
    @(negedge clk);
    ld_start = 0;
    #1;
    n_chk++;
    if (ld_err !== 1'b1 || cpu_stall !== 1'b0 || ld_busy !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bounds_reject: err=%b stall=%b busy=%b rdy=%b want 1 0 0 0",
               ld_err, cpu_stall, ld_busy, ld_ready);
    end
    @(negedge clk); #1;
    n_chk++;
    if (ld_err !== 1'b0 || cpu_stall !== 1'b0 || wr_count != w0) begin
      n_err++;
      $display("FAIL bounds_after: err=%b stall=%b writes=%0d want 0 0 0",
               ld_err, cpu_stall, wr_count - w0);
    end
    run_load(16'd250, 16'd6, 32'hFFFF_FFFF, 0, 0, 32'h0, -1, "bounds_edge");
  endtask

  task automatic test_zero_and_restart;
    int w0 = wr_count;
    @(negedge clk);
    ld_start = 1; ld_base = 16'd100; ld_len = 16'd0;
    @(negedge clk);
    ld_start = 0;
    #1;
    n_chk++;
    if (ld_done !== 1'b1 || cpu_stall !== 1'b1 || ld_busy !== 1'b1 || fetch_valid !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_done: done=%b stall=%b busy=%b fv=%b rdy=%b want 1 1 1 0 0",
               ld_done, cpu_stall, ld_busy, fetch_valid, ld_ready);
    end
    @(negedge clk); #1;
    n_chk++;
    if (ld_done !== 1'b0 || fetch_valid !== 1'b1 || wr_count != w0) begin
      n_err++;
      $display("FAIL zero_len_idle: done=%b fv=%b writes=%0d want 0 1 0",
               ld_done, fetch_valid, wr_count - w0);
    end
    run_load(16'd60, 16'd4, 32'b1101, 0, 0, 32'h0, 1, "restart_ignored");
  endtask

  task automatic test_random;
    logic [15:0] base, len;
    for (int s = 0; s < 6; s++) begin
      base = 16'($urandom_range(0, 250));
      len  = 16'($urandom_range(1, (256 - int'(base)) < 20 ? (256 - int'(base)) : 20));
      run_load(base, len, 32'h0, 1, 0, 32'h0, -1, "random");
    end
  endtask

  initial begin
    clk = 0; rst_n = 0;
    ld_start = 0; ld_base = '0; ld_len = '0; ld_valid = 0; ld_data = '0;
    fetch_addr = 16'd7;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'hDEAD_0000 | 32'(i);
      exp_mem[i] = 32'hDEAD_0000 | 32'(i);
    end
    test_reset();
    test_basic();
    test_fetch();
    test_bubbles();
    test_bounds();
    test_zero_and_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
